serial_add_sub: RTL and testbench

Bit-serial N-bit adder/subtractor. It sits directly downstream of the single-bit half add/sub cell and extends it into a multi-bit datapath. The block accepts two unsigned operands and a select, then processes one bit per clock, LSB first, through a one-bit full add/sub cell with a registered carry/borrow. It returns the N-bit result plus the final carry (add) or borrow (sub), using a start/ready/done handshake.

---
 rtl/add_sub_pkg.sv | 11 +
 rtl/full_add_sub_cell.sv | 19 +
 rtl/serial_add_sub.sv | 81 ++++++++
 tb/tb_serial_add_sub.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/add_sub_pkg.sv
// add_sub_pkg: shared FSM state type, select encodings and default width
package add_sub_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
  localparam logic SEL_ADD = 1'b0;
  localparam logic SEL_SUB = 1'b1;
  localparam int DEF_WIDTH = 8;
endpackage

// File: rtl/full_add_sub_cell.sv
// full_add_sub_cell: one-bit full adder/subtractor from two half add/sub stages
module full_add_sub_cell
  import add_sub_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic select,
  output logic sum,
  output logic cout
);
  logic w_d1, w_c1, w_c2;
  // first half stage combines the operand bits, second folds in the incoming carry/borrow
  assign w_d1 = a ^ b;
  assign w_c1 = (select == SEL_SUB) ? (~a & b) : (a & b);
  assign sum  = w_d1 ^ cin;
  assign w_c2 = (select == SEL_SUB) ? (~w_d1 & cin) : (w_d1 & cin);
  assign cout = w_c1 | w_c2;
endmodule

// File: rtl/serial_add_sub.sv
// serial_add_sub: bit-serial N-bit adder/subtractor, LSB first, start/ready/done handshake
module serial_add_sub
  import add_sub_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             select,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry
);
  state_t           r_state;
  logic [WIDTH-1:0] r_a, r_b, r_sh;
  logic             r_sel, r_c;
  logic [CNT_W-1:0] r_cnt;
  logic             w_sum, w_cout;
  full_add_sub_cell u_cell (
    .a      (r_a[r_cnt]),
    .b      (r_b[r_cnt]),
    .cin    (r_c),
    .select (r_sel),
    .sum    (w_sum),
    .cout   (w_cout)
  );
  // control FSM plus serial datapath; outputs are registered and only published on the last bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sh    <= '0;
      r_sel   <= SEL_ADD;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      carry   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_a     <= a;
          r_b     <= b;
          r_sel   <= select;
          r_c     <= 1'b0;
          r_cnt   <= '0;
          r_state <= RUN;
          ready   <= 1'b0;
          busy    <= 1'b1;
        end
        RUN: begin
          r_c   <= w_cout;
          r_sh  <= {w_sum, r_sh[WIDTH-1:1]};
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            result  <= {w_sum, r_sh[WIDTH-1:1]};
            carry   <= w_cout;
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= DONE;
          end
        end
        DONE: begin
          done    <= 1'b0;
          ready   <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_add_sub.sv
// tb_serial_add_sub: random and directed checks of serial_add_sub against an arithmetic model
module tb_serial_add_sub;
  localparam int W = 8;
  logic         clk, rst_n, start, select;
  logic [W-1:0] a, b;
  logic         ready, busy, done, carry;
  logic [W-1:0] result;
  int tests = 0, failed = 0, cyc = 0;

  serial_add_sub #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .select(select),
    .ready(ready), .busy(busy), .done(done), .result(result), .carry(carry)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  typedef struct {logic [W-1:0] r; logic c; int due;} op_t;
  op_t q[$];
  logic [W-1:0] m_res = '0;
  logic         m_c = 1'b0;

  // reference model: each accepted op finishes W+1 cycles later with plain arithmetic
  always @(negedge clk) begin
    logic   exp_done, exp_ready;
    logic [W:0] s;
    op_t    o;
    cyc++;
    if (!rst_n) begin
      q.delete();
      m_res = '0;
      m_c = 1'b0;
      chk("rst_ready", ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_result", result, 0);
      chk("rst_carry", carry, 0);
    end else begin
      exp_done = q.size() > 0 && q[0].due == cyc;
      if (exp_done) begin
        m_res = q[0].r;
        m_c = q[0].c;
        void'(q.pop_front());
      end
      exp_ready = q.size() == 0 && !exp_done;
      chk("done", done, exp_done);
      chk("busy", busy, q.size() > 0);
      chk("ready", ready, exp_ready);
      chk("result", result, m_res);
      chk("carry", carry, m_c);
      if (exp_ready && start) begin
        if (select) begin
          o.r = a - b;
          o.c = a < b;
        end else begin
          s = {1'b0, a} + {1'b0, b};
          o.r = s[W-1:0];
          o.c = s[W];
        end
        o.due = cyc + W + 1;
        q.push_back(o);
      end
    end
  end

  task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xs,
                        input logic [W-1:0] er, input logic ec, input string nm);
    int n;
    @(posedge clk); #1;
    a = xa; b = xb; select = xs; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = W'($urandom); b = W'($urandom); select = 1'($urandom);
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_lat"}, n, W + 1);
    chk({nm, "_res"}, result, er);
    chk({nm, "_carry"}, carry, ec);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int nd;
    clk = 0; rst_n = 0; start = 0; a = '0; b = '0; select = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    run_op(8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, "t1");
    @(negedge clk);
    chk("t1_ready_back", ready, 1);
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "t2a");
    run_op(8'h05, 8'h07, 1'b1, 8'hFE, 1'b1, "t2b");
    run_op(8'h80, 8'h80, 1'b1, 8'h00, 1'b0, "t3a");
    run_op(8'h07, 8'h05, 1'b1, 8'h02, 1'b0, "t3b");
    // start ignored while busy
    @(posedge clk); #1;
    a = 8'h10; b = 8'h20; select = 0; start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (2) @(posedge clk);
    #1 a = 8'hFF; b = 8'hFF; start = 1;
    @(posedge clk); #1 start = 0;
    nd = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("t4_dones", nd, 1);
    chk("t4_res", result, 8'h30);
    chk("t4_carry", carry, 0);
    // reset mid-run aborts the op
    @(posedge clk); #1;
    a = 8'hAA; b = 8'h55; select = 0; start = 1;
    @(posedge clk); #1 start = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 0;
    #1;
    chk("t5_res", result, 0);
    chk("t5_ready", ready, 1);
    chk("t5_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("t5_nodone", nd, 0);
    run_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, "t5b");
    // back-to-back with start held high
    nd = 0;
    @(posedge clk);
    repeat (510) begin
      #1;
      start = 1; a = W'($urandom); b = W'($urandom); select = 1'($urandom);
      @(negedge clk);
      if (done) nd++;
      @(posedge clk);
    end
    #1 start = 0;
    chk("t6_count", nd >= 50, 1);
    repeat (12) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
